// File: rtl/trng_stream_ctrl.sv
// Entropy bit accumulator with repetition-count health test, word FIFO and
// UART handshake FSM supporting continuous and triggered-burst streaming.
module trng_stream_ctrl #(
    parameter int OUTPUT_SIZE = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int BURST_LEN   = 4,
    parameter int RCT_CUTOFF  = 32
) (
    input  logic                          top_clk,
    input  logic                          top_rst,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          mode_cont,
    input  logic                          trigger,
    input  logic                          tx_busy,
    output logic [OUTPUT_SIZE-1:0]        tx_data,
    output logic                          tx_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          health_fail,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(OUTPUT_SIZE);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int KW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

    tx_state_t state, state_next;

    logic [OUTPUT_SIZE-1:0] acc;
    logic [OUTPUT_SIZE-1:0] acc_next;
    logic [BW-1:0]          bit_cnt;
    logic [RW-1:0]          run_cnt;
    logic [RW-1:0]          run_next;
    logic                   last_bit;
    logic                   take_bit;
    logic                   rct_hit;
    logic                   word_done;

    logic [OUTPUT_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   fifo_full;
    logic                   pop;
    logic                   push_ok;

    logic [KW-1:0]          burst_rem;
    logic                   load_data;

    always_comb begin
        take_bit  = bit_valid && !health_fail;
        acc_next  = {acc[OUTPUT_SIZE-2:0], bit_in};
        run_next  = (run_cnt != '0 && bit_in == last_bit) ? run_cnt + RW'(1) : RW'(1);
        rct_hit   = take_bit && (run_next == RW'(RCT_CUTOFF));
        // The bit that trips the health test never completes a word.
        word_done = take_bit && !rct_hit && (bit_cnt == BW'(OUTPUT_SIZE - 1));
    end

    always_ff @(posedge top_clk) begin
        if (top_rst) begin
            acc         <= '0;
            bit_cnt     <= '0;
            run_cnt     <= '0;
            last_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else if (take_bit) begin
            run_cnt  <= run_next;
            last_bit <= bit_in;
            if (rct_hit) begin
                health_fail <= 1'b1;
                acc         <= '0;
                bit_cnt     <= '0;
            end else begin
                acc     <= acc_next;
                bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        fifo_full = (fifo_count == (PW + 1)'(FIFO_DEPTH));
        pop       = (state == SEND);
        push_ok   = word_done && (!fifo_full || pop);
    end

    always_ff @(posedge top_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= acc_next;
        end
    end

    always_ff @(posedge top_clk) begin
        if (top_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + (PW + 1)'(1);
            end else if (!push_ok && pop) begin
                fifo_count <= fifo_count - (PW + 1)'(1);
            end
            if (word_done && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge top_clk) begin
        if (top_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // tx_data is captured on entry to SEND so it is already valid while tx_start is high.
    always_comb begin
        state_next = state;
        load_data  = 1'b0;
        tx_start   = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0 && !tx_busy && (mode_cont || burst_rem != '0)) begin
                    state_next = SEND;
                    load_data  = 1'b1;
                end
            end
            SEND: begin
                tx_start   = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge top_clk) begin
        if (top_rst) begin
            tx_data <= '0;
        end else if (load_data) begin
            tx_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge top_clk) begin
        if (top_rst) begin
            burst_rem <= '0;
        end else if (mode_cont) begin
            burst_rem <= '0;
        end else if (pop && burst_rem != '0) begin
            burst_rem <= burst_rem - KW'(1);
        end else if (trigger && burst_rem == '0) begin
            burst_rem <= KW'(BURST_LEN);
        end
    end

endmodule

// File: tb/tb_trng_stream_ctrl.sv
// Scoreboard bench for trng_stream_ctrl: default build plus a 12-bit/depth-4 build,
// expected words produced by a bit-queue reference model.
module tb_trng_stream_ctrl;

    localparam int W   = 8;
    localparam int D   = 16;
    localparam int RCT = 32;
    localparam int W2  = 12;
    localparam int D2  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, bit_in, bit_valid, mode_cont, trigger, tx_busy;
    logic                 busy_force, busy_resp;
    logic [W-1:0]         tx_data;
    logic                 tx_start, health_fail, overflow;
    logic [$clog2(D):0]   fifo_count;

    logic                 rst2, bit2, valid2, tx_busy2, busy2_force, busy2_resp;
    logic [W2-1:0]        tx_data2;
    logic                 tx_start2, health_fail2, overflow2;
    logic [$clog2(D2):0]  fifo_count2;

    assign tx_busy  = busy_force | busy_resp;
    assign tx_busy2 = busy2_force | busy2_resp;

    trng_stream_ctrl dut (
        .top_clk(clk), .top_rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .mode_cont(mode_cont), .trigger(trigger), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_start(tx_start), .fifo_count(fifo_count),
        .health_fail(health_fail), .overflow(overflow)
    );

    trng_stream_ctrl #(.OUTPUT_SIZE(W2), .FIFO_DEPTH(D2)) dut2 (
        .top_clk(clk), .top_rst(rst2), .bit_in(bit2), .bit_valid(valid2),
        .mode_cont(1'b1), .trigger(1'b0), .tx_busy(tx_busy2),
        .tx_data(tx_data2), .tx_start(tx_start2), .fifo_count(fifo_count2),
        .health_fail(health_fail2), .overflow(overflow2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: bits collect in a queue; every W bits form one word, oldest bit as MSB.
    bit           bits_q[$];
    bit           m_last;
    int           m_run;
    bit           m_hf, m_ovf, m_hold;
    logic [W-1:0] exp_q[$];
    logic [W2-1:0] exp2_q[$];
    int           n_starts = 0;
    int           n_starts2 = 0;

    task automatic model_reset();
        bits_q.delete();
        exp_q.delete();
        m_run = 0;
        m_hf  = 0;
        m_ovf = 0;
    endtask

    task automatic model_bit(input bit b);
        if (m_hf) return;
        m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
        m_last = b;
        if (m_run >= RCT) begin
            m_hf = 1;
            bits_q.delete();
            return;
        end
        bits_q.push_back(b);
        if (bits_q.size() == W) begin
            logic [W-1:0] w;
            w = '0;
            foreach (bits_q[i]) w = {w[W-2:0], bits_q[i]};
            bits_q.delete();
            if (m_hold && exp_q.size() >= D) m_ovf = 1;
            else exp_q.push_back(w);
        end
    endtask

    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (tx_start) begin
            n_starts++;
            check("tx_start_gap", {31'b0, prev_start}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h expected none", tx_data);
            end else begin
                check("tx_data", tx_data, exp_q.pop_front());
            end
        end
        prev_start = tx_start;
    end

    always @(negedge clk) begin
        if (tx_start2) begin
            n_starts2++;
            if (exp2_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word2: got %0h expected none", tx_data2);
            end else begin
                check("tx_data2", tx_data2, exp2_q.pop_front());
            end
        end
    end

    // Transmitter stand-ins: busy for three cycles after each start.
    initial begin
        busy_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                busy_resp = 1'b1;
                repeat (3) @(negedge clk);
                busy_resp = 1'b0;
            end
        end
    end

    initial begin
        busy2_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start2) begin
                busy2_resp = 1'b1;
                repeat (3) @(negedge clk);
                busy2_resp = 1'b0;
            end
        end
    end

    task automatic feed_bit(input bit b, input int unsigned gap);
        for (int unsigned i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            bit_valid = 1'b0;
        end
        @(posedge clk); #1;
        bit_in    = b;
        bit_valid = 1'b1;
        model_bit(b);
    endtask

    task automatic feed_word(input logic [W-1:0] w, input int unsigned maxgap);
        for (int i = W - 1; i >= 0; i--) feed_bit(w[i], $urandom_range(0, maxgap));
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bit_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        bit_valid = 1'b0;
        trigger   = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pulse_trigger();
        @(posedge clk); #1;
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
        #1;
        quiet(8);
    endtask

    task automatic wait_starts(input int target, input string name);
        int n = 0;
        while (n_starts < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        check(name, n_starts, target);
    endtask

    task automatic feed_word2(input logic [W2-1:0] w);
        exp2_q.push_back(w);
        for (int i = W2 - 1; i >= 0; i--) begin
            @(posedge clk); #1;
            bit2   = w[i];
            valid2 = 1'b1;
        end
        @(posedge clk); #1;
        valid2 = 1'b0;
    endtask

    function automatic logic [W2-1:0] rand_word2();
        logic [W2-1:0] w;
        w    = W2'($urandom);
        w[6] = ~w[5];
        return w;
    endfunction

    initial begin
        int s;
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; mode_cont = 1'b1; trigger = 1'b0;
        busy_force = 1'b0; m_hold = 0;
        rst2 = 1'b1; bit2 = 1'b0; valid2 = 1'b0; busy2_force = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst2 = 1'b0;

        check("rst_tx_data", tx_data, 32'd0);
        check("rst_tx_start", tx_start, 32'd0);
        check("rst_fifo_count", fifo_count, 32'd0);
        check("rst_health_fail", health_fail, 32'd0);
        check("rst_overflow", overflow, 32'd0);

        // Continuous streaming of two known words, then random traffic with gaps.
        s = n_starts;
        feed_word(8'hA5, 0);
        feed_word(8'h3C, 0);
        quiet(1);
        wait_drain("cont_drain");
        check("cont_starts", n_starts, s + 2);
        for (int i = 0; i < 20; i++) feed_word(W'($urandom), 2);
        quiet(1);
        wait_drain("rand_drain");
        check("rand_starts", n_starts, s + 22);
        check("rand_health", health_fail, {31'b0, m_hf});

        // Burst mode: six buffered words, two triggers, then an ignored trigger.
        do_reset();
        mode_cont = 1'b0;
        s = n_starts;
        for (int i = 0; i < 6; i++) feed_word(W'($urandom), 0);
        quiet(5);
        check("burst_buffered", fifo_count, 32'd6);
        check("burst_no_start", n_starts, s);
        pulse_trigger();
        wait_starts(s + 4, "burst1_starts");
        quiet(30);
        check("burst1_exact", n_starts, s + 4);
        check("burst1_left", fifo_count, 32'd2);
        pulse_trigger();
        wait_starts(s + 6, "burst2_starts");
        quiet(5);
        pulse_trigger();
        for (int i = 0; i < 3; i++) feed_word(W'($urandom), 0);
        quiet(30);
        check("burst_wait_words", n_starts, s + 8);
        check("burst_ignored_trig", fifo_count, 32'd1);

        // Reset while the transmitter is mid-word (WAIT_DONE).
        do_reset();
        for (int i = 0; i < 2; i++) feed_word(W'($urandom), 0);
        quiet(2);
        s = n_starts;
        pulse_trigger();
        wait_starts(s + 1, "midrst_start");
        #1;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("midrst_tx_data", tx_data, 32'd0);
        check("midrst_tx_start", tx_start, 32'd0);
        check("midrst_fifo_count", fifo_count, 32'd0);
        check("midrst_overflow", overflow, 32'd0);
        rst = 1'b0;
        quiet(30);
        check("midrst_no_start", n_starts, s + 1);

        // Overflow: transmitter held busy while 17 words arrive.
        mode_cont  = 1'b1;
        busy_force = 1'b1;
        do_reset();
        m_hold = 1;
        for (int i = 0; i < 17; i++) feed_word(W'($urandom), 0);
        quiet(3);
        check("ovf_count", fifo_count, exp_q.size());
        check("ovf_count_full", fifo_count, 32'd16);
        check("ovf_flag", overflow, {31'b0, m_ovf});
        m_hold     = 0;
        busy_force = 1'b0;
        wait_drain("ovf_drain");
        check("ovf_empty", fifo_count, 32'd0);

        // Repetition-count health test: 31 ones pass, 32 ones trip.
        do_reset();
        for (int i = 0; i < 31; i++) feed_bit(1'b1, 0);
        feed_bit(1'b0, 0);
        quiet(2);
        check("rct31_health", health_fail, {31'b0, m_hf});
        wait_drain("rct31_drain");
        check("rct31_health_hold", health_fail, 32'd0);
        do_reset();
        s = n_starts;
        for (int i = 0; i < 31; i++) feed_bit(1'b1, 0);
        quiet(1);
        check("rct_before_edge", health_fail, 32'd0);
        feed_bit(1'b1, 0);
        quiet(1);
        check("rct32_health", health_fail, {31'b0, m_hf});
        for (int i = 0; i < 16; i++) feed_bit(1'($urandom), 0);
        quiet(1);
        wait_drain("rct32_drain");
        quiet(20);
        check("rct32_words", n_starts, s + 3);
        check("rct32_empty", fifo_count, 32'd0);

        // 12-bit, depth-4 build: held then streaming so the pointers wrap.
        busy2_force = 1'b1;
        feed_word2(12'hABC);
        feed_word2(rand_word2());
        feed_word2(rand_word2());
        quiet(2);
        check("w12_buffered", fifo_count2, 32'd3);
        busy2_force = 1'b0;
        for (int i = 0; i < 3; i++) feed_word2(rand_word2());
        begin
            int n = 0;
            while (exp2_q.size() != 0 && n < 2000) begin
                @(posedge clk);
                n++;
            end
        end
        #1;
        quiet(8);
        check("w12_drained", exp2_q.size(), 32'd0);
        check("w12_starts", n_starts2, 32'd6);
        check("w12_empty", fifo_count2, 32'd0);
        check("w12_overflow", overflow2, 32'd0);
        check("w12_health", health_fail2, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
